// File: rtl/mod_exp_if.sv
// Request and divider handshake bundle for the modular-exponentiation controller.
// The slave side is the controller; the master side is its environment.
interface mod_exp_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   base;
  logic [WIDTH-1:0]   exponent;
  logic [WIDTH-1:0]   modulus;
  logic [WIDTH-1:0]   result;
  logic               done;
  logic               busy;
  logic               err;
  logic [2*WIDTH-1:0] div_dividend;
  logic [2*WIDTH-1:0] div_divisor;
  logic               div_start;
  logic [2*WIDTH-1:0] div_remainder;
  logic               div_ready;

  modport slave (
    input  start, base, exponent, modulus,
    input  div_remainder, div_ready,
    output result, done, busy, err,
    output div_dividend, div_divisor, div_start
  );

  modport master (
    output start, base, exponent, modulus,
    output div_remainder, div_ready,
    input  result, done, busy, err,
    input  div_dividend, div_divisor, div_start
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply controller; every reduction is
// delegated to the external divider through a start/ready handshake.
module mod_exp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  mod_exp_if.slave     bus
);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_ARM,
    S_WAIT, S_LOOP, S_SHIFT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic             tgt_r_q, tgt_r_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [DW-1:0]    dvs_q, dvs_d;

  logic [DW-1:0]    prod_rb, prod_bb;
  logic [WIDTH-1:0] e_shr;

  assign prod_rb = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, b_q};
  assign prod_bb = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, b_q};
  assign e_shr   = e_q >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      tgt_r_q <= 1'b0;
      r_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      tgt_r_q <= tgt_r_d;
      r_q     <= r_d;
      b_q     <= b_d;
      e_q     <= e_d;
      m_q     <= m_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    tgt_r_d = tgt_r_q;
    r_d     = r_q;
    b_d     = b_q;
    e_d     = e_q;
    m_d     = m_q;
    res_d   = res_q;
    err_d   = err_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          b_d     = bus.base;
          e_d     = bus.exponent;
          m_d     = bus.modulus;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (m_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (m_q == WIDTH'(1)) begin
          res_d   = '0;
          state_d = S_DONE;
        end else if (e_q == '0) begin
          res_d   = WIDTH'(1);
          state_d = S_DONE;
        end else begin
          // First reduction brings the base below m.
          r_d     = WIDTH'(1);
          dvd_d   = {{WIDTH{1'b0}}, b_q};
          dvs_d   = {{WIDTH{1'b0}}, m_q};
          tgt_r_d = 1'b0;
          ret_d   = S_LOOP;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      // div_ready may still be high from the previous division here.
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.div_ready) begin
          if (tgt_r_q) r_d = bus.div_remainder[WIDTH-1:0];
          else         b_d = bus.div_remainder[WIDTH-1:0];
          state_d = ret_q;
        end
      end
      S_LOOP: begin
        if (e_q[0]) begin
          dvd_d   = prod_rb;
          tgt_r_d = 1'b1;
          ret_d   = S_SHIFT;
          state_d = S_ISSUE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        e_d = e_shr;
        if (e_shr == '0) begin
          res_d   = r_q;
          state_d = S_DONE;
        end else begin
          dvd_d   = prod_bb;
          tgt_r_d = 1'b0;
          ret_d   = S_LOOP;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.result       = res_q;
  assign bus.err          = err_q;
  assign bus.done         = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.div_start    = (state_q == S_ISSUE);
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: random-latency divider model plus a plain
// repeated-multiplication reference for the expected result.
module tb_mod_exp_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_exp_if #(.WIDTH(W)) bus ();

  mod_exp_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int dones = 0;
  bit slow_div = 1'b0;

  logic [2*W-1:0] dv_a, dv_b;
  int             lat_cnt;

  always @(posedge clk) begin
    if (rst) begin
      bus.div_ready     <= 1'b0;
      bus.div_remainder <= '0;
      lat_cnt           <= 0;
    end else if (bus.div_start) begin
      dv_a          <= bus.div_dividend;
      dv_b          <= bus.div_divisor;
      bus.div_ready <= 1'b0;
      lat_cnt       <= slow_div ? 40 : int'($urandom_range(1, 40));
    end else if (lat_cnt > 0) begin
      if (lat_cnt == 1) begin
        bus.div_ready     <= 1'b1;
        bus.div_remainder <= (dv_b == 0) ? '0 : dv_a % dv_b;
      end
      lat_cnt <= lat_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.div_start) starts <= starts + 1;
    if (!rst && bus.done) dones <= dones + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input int b, input int e, input int m,
                                    output int res, output int er,
                                    output int calls);
    int acc;
    er = 0;
    calls = 0;
    if (m == 0) begin
      res = 0;
      er = 1;
    end else if (m == 1) begin
      res = 0;
    end else if (e == 0) begin
      res = 1;
    end else begin
      acc = 1;
      for (int i = 0; i < e; i++) acc = (acc * b) % m;
      res = acc;
      calls = 1 + $countones(e) + ($clog2(e + 1) - 1);
    end
  endfunction

  task automatic run(input string tag, input int b, input int e,
                     input int m, input bit inject, output int cyc);
    int exp_res, exp_err, exp_calls;
    int s0, d0;
    bit seen;
    ref_model(b, e, m, exp_res, exp_err, exp_calls);
    @(negedge clk);
    s0 = starts;
    d0 = dones;
    bus.start    = 1'b1;
    bus.base     = W'(b);
    bus.exponent = W'(e);
    bus.modulus  = W'(m);
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (inject && cyc == 4) begin
        bus.start    = 1'b1;
        bus.base     = 8'd9;
        bus.exponent = 8'd3;
        bus.modulus  = 8'd11;
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_result"}, int'(bus.result), exp_res);
    chk({tag, "_err"}, int'(bus.err), exp_err);
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_div_calls"}, starts - s0, exp_calls);
    chk({tag, "_done_pulses"}, dones - d0, 1);
  endtask

  initial begin
    int cyc;
    int b, e, m;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_div_start", int'(bus.div_start), 0);
    chk("rst_dividend", int'(bus.div_dividend), 0);
    chk("rst_divisor", int'(bus.div_divisor), 0);
    rst = 1'b0;

    run("p5e6", 5, 6, 23, 1'b0, cyc);
    chk("p5e6_known", int'(bus.result), 8);
    run("p5e15", 5, 15, 23, 1'b0, cyc);
    chk("p5e15_known", int'(bus.result), 19);
    run("dh_secret", int'(bus.result), 6, 23, 1'b0, cyc);
    chk("dh_known", int'(bus.result), 2);
    run("p200e2", 200, 2, 251, 1'b0, cyc);
    run("p50e1", 50, 1, 23, 1'b0, cyc);
    run("exp0", 7, 0, 23, 1'b0, cyc);
    chk("exp0_latency_le3", int'(cyc <= 3), 1);
    run("mod1", 5, 6, 1, 1'b0, cyc);
    run("mod0", 5, 6, 0, 1'b0, cyc);
    run("err_clear", 3, 4, 13, 1'b0, cyc);
    run("busy_ignore", 5, 6, 23, 1'b1, cyc);

    // Reset while the controller sits in WAIT on a slow division.
    slow_div = 1'b1;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base     = 8'd5;
    bus.exponent = 8'd15;
    bus.modulus  = 8'd23;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.div_start; i++) @(negedge clk);
    chk("mid_rst_issue_seen", int'(bus.div_start), 1);
    repeat (3) @(negedge clk);
    chk("mid_rst_in_wait", int'(bus.busy && !bus.div_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_result", int'(bus.result), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    chk("mid_rst_div_start", int'(bus.div_start), 0);
    chk("mid_rst_dividend", int'(bus.div_dividend), 0);
    chk("mid_rst_divisor", int'(bus.div_divisor), 0);
    slow_div = 1'b0;
    run("after_rst", 5, 6, 23, 1'b0, cyc);

    for (int k = 0; k < 24; k++) begin
      b = int'($urandom_range(0, 255));
      e = int'($urandom_range(0, 255));
      m = (k % 8 == 0) ? int'($urandom_range(0, 2))
                       : int'($urandom_range(2, 255));
      run("rand", b, e, m, 1'b0, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Modular-exponentiation controller for the Diffie-Hellman datapath. Computes result = base^exponent mod modulus by right-to-left square-and-multiply.
- Sits directly upstream of the shared divider. It forms each product, drives the product to the divider as dividend, and consumes the divider's remainder as the reduced value.
- It does not divide internally. Every modular reduction goes through the external divider handshake.

Parameters:
- WIDTH, 8, operand width of base/exponent/modulus/result. The divider interface is 2*WIDTH wide, so any WIDTH x WIDTH product fits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  WIDTH  base operand; captured on accepted start
- exponent  in  WIDTH  exponent; captured on accepted start
- modulus  in  WIDTH  modulus; captured on accepted start
- result  out  WIDTH  final value; held until next accepted start
- done  out  1  one-cycle pulse when result/err are valid
- busy  out  1  high from the cycle after accepted start through the done cycle
- err  out  1  set with done when modulus==0; cleared on next accepted start
- div_dividend  out  2*WIDTH  value to reduce
- div_divisor  out  2*WIDTH  modulus, zero-extended
- div_start  out  1  one-cycle pulse launching a division
- div_remainder  in  2*WIDTH  divider remainder; upper WIDTH bits guaranteed 0
- div_ready  in  1  divider result valid (level)

Behaviour:
- Reset values: result=0, done=0, busy=0, err=0, div_start=0, div_dividend=0, div_divisor=0, FSM=IDLE.
- Reset mid-operation aborts immediately. The in-flight divider result is discarded, because the divider shares rst.
- Internal registers: r (accumulator), b (running square), e (remaining exponent), m, and ret (return state).
- IDLE: on start=1, capture operands, set busy, clear err, go to CHECK. start while busy is ignored.
- CHECK:
  - m==0: result=0, err=1, go to DONE.
  - m==1: result=0, go to DONE.
  - e==0: result=1, go to DONE.
  - otherwise: r=1, dividend={0,base}, ret=LOOP, go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle, div_divisor={0,m}, then go to ARM.
- ARM: wait one cycle, ignoring div_ready (it may be stale from the previous division), then go to WAIT.
- WAIT: hold while div_ready=0. On div_ready=1, write div_remainder[WIDTH-1:0] into the target register (b or r, per ret), then go to ret.
- The first reduction writes b = base mod m.
- LOOP:
  - if e[0]=1: dividend=r*b, target r, ret=SHIFT, go to ISSUE.
  - else go to SHIFT.
- SHIFT:
  - e = e>>1.
  - If new e==0: result=r, go to DONE.
  - Else: dividend=b*b, target b, ret=LOOP, go to ISSUE.
  - There is no final unused squaring.
- DONE: done=1 for one cycle, busy drops the next cycle, return to IDLE. start is accepted again in the cycle after DONE.
- Arithmetic: products are unsigned WIDTH x WIDTH giving 2*WIDTH bits, with no truncation. r and b are always < m after reduction.
- div_dividend/div_divisor hold stable from ISSUE until WAIT completes.
- Divider call count for e>0, m>=2 is exactly 1 + popcount(e) + (bitlen(e) - 1). Total latency depends on the divider.

Test Plan:
- Bench setup: connect the real divider, plus a behavioural divider with a random 1-40 cycle latency. Count div_start pulses in every test.
- base=5, exp=6, mod=23 -> result=8, err=0, exactly 5 div_start pulses, one done pulse.
- base=5, exp=15, mod=23 -> result=19 (8 div_start pulses); then base=19, exp=6, mod=23 -> result=2. Full DH shared-secret check.
- base=200, exp=2, mod=251 -> result=91 (product 40000 exercises the full 16-bit dividend). base=50, exp=1, mod=23 -> result=4 (2 div_start pulses).
- Edge cases:
  - exp=0, mod=23 -> result=1, no div_start, done within 3 cycles of start.
  - mod=1 -> result=0, no div_start.
  - mod=0 -> result=0, err=1, no div_start.
- Protocol checks:
  - Pulse start again while busy -> ignored; result still 8 for the 5^6 mod 23 run.
  - Assert rst while WAIT holds -> next cycle all outputs at reset values, FSM in IDLE. A fresh start then yields the correct result.
